lc3b_ctrl_fsm: RTL and testbench

Microsequencer for the LC-3b datapath. It is a Moore state machine that drives the control signals for the ALU, REG_FILE, PC_MUX, IR, MAR/MDR and the memory handshake. It runs fetch, decode and execute for ADD, AND, XOR, BR, JMP, LDW, STW and LEA. It decodes IR fields into register selects and halts on an unsupported opcode or a memory timeout.

---
 rtl/lc3b_defs_pkg.sv | 58 +++++
 rtl/lc3b_mem_wait.sv | 31 +++
 rtl/lc3b_ctrl_fsm.sv | 182 ++++++++++++++++++
 tb/tb_lc3b_ctrl_fsm.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_defs_pkg.sv
// Shared encodings for the LC-3b control path: opcodes, mux selects, ALU ops
// and the microsequencer state numbering (visible on the STATE debug port).
package lc3b_defs;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDW = 4'b0110;
   localparam logic [3:0] OP_STW = 4'b0111;
   localparam logic [3:0] OP_XOR = 4'b1001;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_LEA = 4'b1110;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'd0,
      ALU_AND   = 2'd1,
      ALU_XOR   = 2'd2,
      ALU_PASSA = 2'd3
   } alu_k_e;

   typedef enum logic [1:0] {
      PC_INC   = 2'd0,
      PC_BUS   = 2'd1,
      PC_ADDER = 2'd2
   } pc_sel_e;

   typedef enum logic [1:0] {
      A2_ZERO    = 2'd0,
      A2_OFF6    = 2'd1,
      A2_PCOFF9  = 2'd2,
      A2_PCOFF11 = 2'd3
   } addr2_sel_e;

   typedef enum logic [4:0] {
      S_IDLE     = 5'd0,
      S_FETCH1   = 5'd1,
      S_FETCH2   = 5'd2,
      S_FETCH3   = 5'd3,
      S_DECODE   = 5'd4,
      S_EXEC_ALU = 5'd5,
      S_BR       = 5'd6,
      S_JMP      = 5'd7,
      S_LEA      = 5'd8,
      S_LDW1     = 5'd9,
      S_LDW2     = 5'd10,
      S_LDW3     = 5'd11,
      S_STW1     = 5'd12,
      S_STW2     = 5'd13,
      S_STW3     = 5'd14,
      S_HALT     = 5'd15
   } state_e;

   // States that wait on MEM_R and are guarded by the timeout counter.
   function automatic logic is_mem_state(input state_e s);
      return (s == S_FETCH2) || (s == S_LDW2) || (s == S_STW3);
   endfunction

endpackage

// File: rtl/lc3b_mem_wait.sv
// Memory wait timeout counter. Held at zero while clr is high; counts the
// cycles a memory state has spent without MEM_R. timeout flags the last
// allowed waiting cycle, so a ready on that same cycle still succeeds.
module lc3b_mem_wait #(
   parameter int unsigned MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic cnt_en,
   output logic timeout
);

   localparam int unsigned CW = $clog2(MAX + 1);

   logic [CW-1:0] count;

   // Wait-cycle count: cleared outside memory states, advances on each stalled cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (cnt_en && !timeout) begin
         count <= count + 1'b1;
      end
   end

   assign timeout = cnt_en && (count == CW'(MAX - 1));

endmodule

// File: rtl/lc3b_ctrl_fsm.sv
// LC-3b microsequencer: Moore control FSM for fetch/decode/execute of
// ADD, AND, XOR, BR, JMP, LDW, STW and LEA, with a memory-wait timeout.
module lc3b_ctrl_fsm
   import lc3b_defs::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] IR,
   input  logic        N,
   input  logic        Z,
   input  logic        P,
   input  logic        MEM_R,
   output logic        LD_IR,
   output logic        LD_PC,
   output logic        LD_REG,
   output logic        LD_CC,
   output logic        LD_MAR,
   output logic        LD_MDR,
   output logic [1:0]  PC_SEL,
   output logic [1:0]  ALU_K,
   output logic        SR2_IMM,
   output logic [2:0]  DR,
   output logic [2:0]  SR1,
   output logic [2:0]  SR2,
   output logic        ADDR1_SEL,
   output logic [1:0]  ADDR2_SEL,
   output logic        LSHF1,
   output logic        GATE_PC,
   output logic        GATE_ALU,
   output logic        GATE_MDR,
   output logic        GATE_MARMUX,
   output logic        MEM_EN,
   output logic        MEM_WE,
   output logic        HALT,
   output logic        BUS_ERR,
   output logic [4:0]  STATE
);

   state_e state, state_nx;
   logic   in_mem, timeout, ben, bus_err_q;
   logic   ir_unused;

   // IR[4:3] carry no control information for the supported instructions.
   assign ir_unused = ^IR[4:3];

   assign in_mem = is_mem_state(state);
   assign ben    = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);

   lc3b_mem_wait #(.MAX(MEM_WAIT_MAX)) u_mem_wait (
      .clk     (clk),
      .rst     (rst),
      .clr     (!in_mem),
      .cnt_en  (in_mem && !MEM_R),
      .timeout (timeout)
   );

   // State register and sticky bus-error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         bus_err_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (timeout) bus_err_q <= 1'b1;
      end
   end

   // Next-state and Moore control outputs decoded from state and IR.
   always_comb begin
      state_nx    = state;
      LD_IR       = 1'b0;
      LD_PC       = 1'b0;
      LD_REG      = 1'b0;
      LD_CC       = 1'b0;
      LD_MAR      = 1'b0;
      LD_MDR      = 1'b0;
      PC_SEL      = PC_INC;
      ALU_K       = ALU_ADD;
      SR2_IMM     = 1'b0;
      DR          = 3'd0;
      SR1         = 3'd0;
      SR2         = 3'd0;
      ADDR1_SEL   = 1'b0;
      ADDR2_SEL   = A2_ZERO;
      LSHF1       = 1'b0;
      GATE_PC     = 1'b0;
      GATE_ALU    = 1'b0;
      GATE_MDR    = 1'b0;
      GATE_MARMUX = 1'b0;
      MEM_EN      = 1'b0;
      MEM_WE      = 1'b0;
      HALT        = 1'b0;
      unique case (state)
         S_IDLE: state_nx = S_FETCH1;
         S_FETCH1: begin
            GATE_PC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PC_SEL = PC_INC;
            state_nx = S_FETCH2;
         end
         S_FETCH2: begin
            MEM_EN = 1'b1; LD_MDR = 1'b1;
            if (MEM_R)        state_nx = S_FETCH3;
            else if (timeout) state_nx = S_HALT;
         end
         S_FETCH3: begin
            GATE_MDR = 1'b1; LD_IR = 1'b1;
            state_nx = S_DECODE;
         end
         S_DECODE: begin
            case (IR[15:12])
               OP_ADD, OP_AND, OP_XOR: state_nx = S_EXEC_ALU;
               OP_BR:                  state_nx = S_BR;
               OP_JMP:                 state_nx = S_JMP;
               OP_LDW:                 state_nx = S_LDW1;
               OP_STW:                 state_nx = S_STW1;
               OP_LEA:                 state_nx = S_LEA;
               default:                state_nx = S_HALT;
            endcase
         end
         S_EXEC_ALU: begin
            DR = IR[11:9]; SR1 = IR[8:6]; SR2 = IR[2:0]; SR2_IMM = IR[5];
            case (IR[15:12])
               OP_AND:  ALU_K = ALU_AND;
               OP_XOR:  ALU_K = ALU_XOR;
               default: ALU_K = ALU_ADD;
            endcase
            GATE_ALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
            state_nx = S_FETCH1;
         end
         S_BR: begin
            if (ben) begin
               LD_PC = 1'b1; PC_SEL = PC_ADDER; ADDR1_SEL = 1'b0;
               ADDR2_SEL = A2_PCOFF9; LSHF1 = 1'b1;
            end
            state_nx = S_FETCH1;
         end
         S_JMP: begin
            SR1 = IR[8:6]; ADDR1_SEL = 1'b1; ADDR2_SEL = A2_ZERO;
            PC_SEL = PC_ADDER; LD_PC = 1'b1;
            state_nx = S_FETCH1;
         end
         S_LEA: begin
            DR = IR[11:9]; ADDR1_SEL = 1'b0; ADDR2_SEL = A2_PCOFF9; LSHF1 = 1'b1;
            GATE_MARMUX = 1'b1; LD_REG = 1'b1;
            state_nx = S_FETCH1;
         end
         S_LDW1, S_STW1: begin
            SR1 = IR[8:6]; ADDR1_SEL = 1'b1; ADDR2_SEL = A2_OFF6; LSHF1 = 1'b1;
            GATE_MARMUX = 1'b1; LD_MAR = 1'b1;
            state_nx = (state == S_LDW1) ? S_LDW2 : S_STW2;
         end
         S_LDW2: begin
            MEM_EN = 1'b1; LD_MDR = 1'b1;
            if (MEM_R)        state_nx = S_LDW3;
            else if (timeout) state_nx = S_HALT;
         end
         S_LDW3: begin
            DR = IR[11:9]; GATE_MDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
            state_nx = S_FETCH1;
         end
         S_STW2: begin
            SR1 = IR[11:9]; ALU_K = ALU_PASSA; GATE_ALU = 1'b1; LD_MDR = 1'b1;
            state_nx = S_STW3;
         end
         S_STW3: begin
            MEM_EN = 1'b1; MEM_WE = 1'b1;
            if (MEM_R)        state_nx = S_FETCH1;
            else if (timeout) state_nx = S_HALT;
         end
         S_HALT: begin
            HALT = 1'b1;
            state_nx = S_HALT;
         end
         default: state_nx = S_HALT;
      endcase
   end

   assign BUS_ERR = bus_err_q;
   assign STATE   = state;

endmodule

// File: tb/tb_lc3b_ctrl_fsm.sv
// Directed bench for the LC-3b microsequencer: walks each instruction class,
// the memory-wait boundary, the timeout halt, illegal opcode and async reset.
module tb_lc3b_ctrl_fsm;

   localparam logic [4:0] ST_IDLE = 5'd0,  ST_F1 = 5'd1,  ST_F2 = 5'd2,  ST_F3 = 5'd3;
   localparam logic [4:0] ST_DEC  = 5'd4,  ST_ALU = 5'd5, ST_BR = 5'd6,  ST_JMP = 5'd7;
   localparam logic [4:0] ST_LEA  = 5'd8,  ST_LDW1 = 5'd9, ST_LDW2 = 5'd10, ST_LDW3 = 5'd11;
   localparam logic [4:0] ST_STW1 = 5'd12, ST_STW2 = 5'd13, ST_STW3 = 5'd14, ST_HALT = 5'd15;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] IR;
   logic        N, Z, P, MEM_R;
   logic        LD_IR, LD_PC, LD_REG, LD_CC, LD_MAR, LD_MDR;
   logic [1:0]  PC_SEL, ALU_K, ADDR2_SEL;
   logic        SR2_IMM, ADDR1_SEL, LSHF1;
   logic [2:0]  DR, SR1, SR2;
   logic        GATE_PC, GATE_ALU, GATE_MDR, GATE_MARMUX;
   logic        MEM_EN, MEM_WE, HALT, BUS_ERR;
   logic [4:0]  STATE;

   int          checks = 0;
   int          errors = 0;
   logic [4:0]  exp_q[$];

   lc3b_ctrl_fsm #(.MEM_WAIT_MAX(15)) dut (
      .clk(clk), .rst(rst), .IR(IR), .N(N), .Z(Z), .P(P), .MEM_R(MEM_R),
      .LD_IR(LD_IR), .LD_PC(LD_PC), .LD_REG(LD_REG), .LD_CC(LD_CC),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .PC_SEL(PC_SEL), .ALU_K(ALU_K),
      .SR2_IMM(SR2_IMM), .DR(DR), .SR1(SR1), .SR2(SR2),
      .ADDR1_SEL(ADDR1_SEL), .ADDR2_SEL(ADDR2_SEL), .LSHF1(LSHF1),
      .GATE_PC(GATE_PC), .GATE_ALU(GATE_ALU), .GATE_MDR(GATE_MDR),
      .GATE_MARMUX(GATE_MARMUX), .MEM_EN(MEM_EN), .MEM_WE(MEM_WE),
      .HALT(HALT), .BUS_ERR(BUS_ERR), .STATE(STATE)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // Checking task
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Driver tasks; all sampling and driving happen on the falling edge
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("reset_state", 32'(STATE), 32'(ST_IDLE));
      check("reset_bus_err", 32'(BUS_ERR), 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // From an exec state or IDLE: run a zero-wait fetch and land in the dispatch state.
   task automatic fetch_to_decode(input logic [15:0] ir);
      IR = ir;
      MEM_R = 1'b1;
      tick(); check("fetch1_state", 32'(STATE), 32'(ST_F1));
      tick(); check("fetch2_state", 32'(STATE), 32'(ST_F2));
      tick(); check("fetch3_state", 32'(STATE), 32'(ST_F3));
      tick(); check("decode_state", 32'(STATE), 32'(ST_DEC));
      tick();
   endtask

   initial begin
      rst = 1'b1; IR = 16'h0000; N = 1'b0; Z = 1'b0; P = 1'b0; MEM_R = 1'b0;
      @(negedge clk);
      check("rst_state", 32'(STATE), 32'(ST_IDLE));
      check("rst_outs", 32'({LD_IR, LD_PC, LD_REG, LD_CC, LD_MAR, LD_MDR, GATE_PC,
                             GATE_ALU, GATE_MDR, GATE_MARMUX, MEM_EN, MEM_WE, HALT, BUS_ERR}), 0);
      @(negedge clk);
      rst = 1'b0;

      // ADD R1,R2,R3: expected state trace through the scoreboard queue
      IR = 16'h1283; MEM_R = 1'b1;
      exp_q = {ST_F1, ST_F2, ST_F3, ST_DEC, ST_ALU, ST_F1};
      while (exp_q.size() > 0) begin
         logic [4:0] e;
         e = exp_q.pop_front();
         tick();
         check("add_trace", 32'(STATE), 32'(e));
         if (e == ST_F1 && exp_q.size() == 5)
            check("fetch1_outs", 32'({GATE_PC, LD_MAR, LD_PC, PC_SEL}), 32'b1_1_1_00);
         if (e == ST_F2)
            check("fetch2_outs", 32'({MEM_EN, LD_MDR, MEM_WE}), 32'b110);
         if (e == ST_F3)
            check("fetch3_outs", 32'({GATE_MDR, LD_IR}), 32'b11);
         if (e == ST_DEC)
            check("decode_outs", 32'({LD_IR, LD_PC, LD_REG, GATE_PC, MEM_EN}), 0);
         if (e == ST_ALU)
            check("add_exec", 32'({DR, SR1, SR2, ALU_K, SR2_IMM, LD_REG, LD_CC, GATE_ALU}),
                  32'({3'd1, 3'd2, 3'd3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1}));
      end
      do_reset();

      // AND register form and XOR immediate form
      fetch_to_decode(16'h5283);
      check("and_exec", 32'({STATE, ALU_K, DR, SR1, SR2}), 32'({ST_ALU, 2'd1, 3'd1, 3'd2, 3'd3}));
      fetch_to_decode(16'h9725);
      check("xor_exec", 32'({STATE, ALU_K, DR, SR1, SR2_IMM, SR2}),
            32'({ST_ALU, 2'd2, 3'd3, 3'd4, 1'b1, 3'd5}));

      // BRz +5 taken, not taken, and nzp=000 never taken
      Z = 1'b1;
      fetch_to_decode(16'h0405);
      check("br_taken", 32'({STATE, LD_PC, PC_SEL, ADDR1_SEL, ADDR2_SEL, LSHF1}),
            32'({ST_BR, 1'b1, 2'd2, 1'b0, 2'd2, 1'b1}));
      Z = 1'b0;
      fetch_to_decode(16'h0405);
      check("br_not_taken", 32'({STATE, LD_PC}), 32'({ST_BR, 1'b0}));
      N = 1'b1; Z = 1'b1; P = 1'b1;
      fetch_to_decode(16'h0005);
      check("br_nop", 32'({STATE, LD_PC}), 32'({ST_BR, 1'b0}));
      N = 1'b0; Z = 1'b0; P = 1'b0;

      // JMP R7 and LEA R2
      fetch_to_decode(16'hC1C0);
      check("jmp", 32'({STATE, SR1, ADDR1_SEL, ADDR2_SEL, PC_SEL, LD_PC}),
            32'({ST_JMP, 3'd7, 1'b1, 2'd0, 2'd2, 1'b1}));
      fetch_to_decode(16'hE403);
      check("lea", 32'({STATE, DR, ADDR1_SEL, ADDR2_SEL, LSHF1, GATE_MARMUX, LD_REG, LD_CC}),
            32'({ST_LEA, 3'd2, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0}));

      // LDW with three stalled cycles in LDW2
      fetch_to_decode(16'h6283);
      check("ldw1", 32'({STATE, SR1, ADDR1_SEL, ADDR2_SEL, LSHF1, GATE_MARMUX, LD_MAR}),
            32'({ST_LDW1, 3'd2, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1}));
      MEM_R = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         check("ldw2_wait", 32'({STATE, MEM_EN, LD_MDR}), 32'({ST_LDW2, 1'b1, 1'b1}));
         if (i == 3) MEM_R = 1'b1;
         tick();
      end
      check("ldw3", 32'({STATE, DR, GATE_MDR, LD_REG, LD_CC}), 32'({ST_LDW3, 3'd1, 1'b1, 1'b1, 1'b1}));

      // STW
      fetch_to_decode(16'h7283);
      check("stw1", 32'({STATE, SR1, ADDR1_SEL, ADDR2_SEL, LD_MAR}), 32'({ST_STW1, 3'd2, 1'b1, 2'd1, 1'b1}));
      tick();
      check("stw2", 32'({STATE, SR1, ALU_K, GATE_ALU, LD_MDR}), 32'({ST_STW2, 3'd1, 2'd3, 1'b1, 1'b1}));
      tick();
      check("stw3", 32'({STATE, MEM_EN, MEM_WE}), 32'({ST_STW3, 1'b1, 1'b1}));

      // Ready on the 15th waiting cycle of FETCH2 still succeeds
      IR = 16'h1283;
      tick(); check("lim_fetch1", 32'(STATE), 32'(ST_F1));
      MEM_R = 1'b0;
      tick();
      for (int i = 0; i < 15; i++) begin
         check("lim_fetch2", 32'(STATE), 32'(ST_F2));
         if (i == 14) MEM_R = 1'b1;
         tick();
      end
      check("lim_success", 32'({STATE, BUS_ERR}), 32'({ST_F3, 1'b0}));
      tick(); tick();
      check("lim_exec", 32'(STATE), 32'(ST_ALU));

      // MEM_R stuck low in FETCH2: 15 cycles then HALT with BUS_ERR
      tick(); check("to_fetch1", 32'(STATE), 32'(ST_F1));
      MEM_R = 1'b0;
      tick();
      for (int i = 0; i < 15; i++) begin
         check("to_fetch2", 32'(STATE), 32'(ST_F2));
         tick();
      end
      check("timeout_halt", 32'({STATE, HALT, BUS_ERR}), 32'({ST_HALT, 1'b1, 1'b1}));
      MEM_R = 1'b1;
      tick(); tick(); tick();
      check("halt_sticky", 32'({STATE, HALT, BUS_ERR}), 32'({ST_HALT, 1'b1, 1'b1}));
      check("halt_outs", 32'({LD_IR, LD_PC, LD_REG, LD_CC, LD_MAR, LD_MDR, GATE_PC,
                              GATE_ALU, GATE_MDR, GATE_MARMUX, MEM_EN, MEM_WE}), 0);
      do_reset();

      // Illegal opcode halts without a bus error
      fetch_to_decode(16'hD000);
      check("illegal_halt", 32'({STATE, HALT, BUS_ERR}), 32'({ST_HALT, 1'b1, 1'b0}));
      tick();
      check("illegal_sticky", 32'({STATE, HALT}), 32'({ST_HALT, 1'b1}));
      do_reset();

      // Async reset in the middle of an STW3 wait
      fetch_to_decode(16'h7283);
      MEM_R = 1'b0;
      tick(); tick();
      check("pre_rst_stw3", 32'({STATE, MEM_EN, MEM_WE}), 32'({ST_STW3, 1'b1, 1'b1}));
      #2 rst = 1'b1;
      #1;
      check("async_rst", 32'({STATE, MEM_EN, MEM_WE}), 32'({ST_IDLE, 1'b0, 1'b0}));
      @(negedge clk);
      rst = 1'b0;
      MEM_R = 1'b1;
      tick();
      check("restart_fetch1", 32'(STATE), 32'(ST_F1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
